// File: rtl/ram32_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module     : ram32_ctrl_if
//  Description: Request/response handshake bundle between a requester and
//               the RAM32 initiator (ram32_ctrl).
//  Revision   : 1.0 - initial release
// ============================================================================
interface ram32_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;

   // requester side
   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   // controller side
   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface
`default_nettype wire

// File: rtl/ram32_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : ram32_ctrl
//  Description: Initiator for a RAM32 port. Zero-fills every word after reset,
//               then serves single read/write requests on a valid/ready
//               request channel and returns data on a valid/ready response
//               channel (writes echo the stored data).
//  Revision   : 1.0 - initial release
// ============================================================================
module ram32_ctrl #(
   parameter int DATA_W         = 16,
   parameter int ADDR_W         = 5,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   ram32_ctrl_if.slave       bus,
   output logic              init_done,
   output logic [DATA_W-1:0] ram_in,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_write,
   input  logic [DATA_W-1:0] ram_out
);

   typedef enum logic [1:0] {
      CLEAR  = 2'd0,
      IDLE   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t            state;
   // Top bit set means every address has been loaded; the count stops there.
   logic [ADDR_W:0]   clr_cnt;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;

   // Requests are taken only while idle.
   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_rdata = rsp_rdata;

   // Controller FSM with registered RAM-side and response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= CLEAR_ON_RESET ? CLEAR : IDLE;
         clr_cnt   <= '0;
         init_done <= ~CLEAR_ON_RESET;
         ram_in    <= '0;
         ram_addr  <= '0;
         ram_write <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         case (state)
            CLEAR: begin
               if (!clr_cnt[ADDR_W]) begin
                  ram_addr  <= clr_cnt[ADDR_W-1:0];
                  ram_in    <= '0;
                  ram_write <= 1'b1;
                  clr_cnt   <= clr_cnt + 1'b1;
               end else begin
                  // The last word is written at this edge.
                  ram_write <= 1'b0;
                  init_done <= 1'b1;
                  state     <= IDLE;
               end
            end
            IDLE: begin
               if (bus.req_valid) begin
                  // ram_write and ram_in double as the latched op and wdata.
                  ram_addr  <= bus.req_addr;
                  ram_in    <= bus.req_wdata;
                  ram_write <= bus.req_write;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               rsp_rdata <= ram_write ? ram_in : ram_out;
               ram_write <= 1'b0;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               ram_write <= 1'b0;
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ram32_ctrl.sv
`default_nettype none
// ============================================================================
//  Module     : tb_ram32_ctrl
//  Description: Self-checking bench for ram32_ctrl with a RAM32 model and a
//               word-array reference of the memory contents.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_ram32_ctrl;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              init_done;
   logic [DATA_W-1:0] ram_in;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_write;
   logic [DATA_W-1:0] ram_out;

   ram32_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   ram32_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .init_done (init_done),
      .ram_in    (ram_in),
      .ram_addr  (ram_addr),
      .ram_write (ram_write),
      .ram_out   (ram_out)
   );

   always #5 clk = ~clk;

   // RAM32 model: garbage at power-up, synchronous write, combinational read.
   logic              scramble = 1'b1;
   logic [DATA_W-1:0] ram_mem [DEPTH];
   always @(posedge clk) begin
      if (scramble) begin
         for (int i = 0; i < DEPTH; i++) ram_mem[i] <= 16'($urandom);
      end else if (ram_write) begin
         ram_mem[ram_addr] <= ram_in;
      end
   end
   assign ram_out = ram_mem[ram_addr];

   logic [DATA_W-1:0] ref_mem [DEPTH];
   logic [DATA_W-1:0] pat [8] = '{16'h0070, 16'h0065, 16'h0063, 16'h0075,
                                  16'h006C, 16'h0069, 16'h0061, 16'h0072};
   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Release reset and follow the zero-fill edge by edge; a request is held
   // pending throughout to show it is ignored.
   task automatic run_clear();
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 5'($urandom);
      bus.req_wdata = 16'hBEEF;
      bus.rsp_ready = 1'b1;
      rst_n = 1'b1;
      for (int k = 1; k <= DEPTH + 1; k++) begin
         tick();
         if (k <= DEPTH) begin
            check("clr_wr", {ram_write, ram_addr, ram_in}, {1'b1, 5'(k - 1), 16'h0000});
            check("clr_busy", {init_done, bus.req_ready, bus.rsp_valid}, 3'b000);
         end else begin
            check("clr_end", {ram_write, init_done, bus.req_ready}, 3'b011);
         end
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      tick();
      check("idle_after_clr", {ram_write, bus.rsp_valid, bus.req_ready}, 3'b001);
   endtask

   // One request/response transaction with `stall` cycles of response backpressure.
   task automatic do_op(input logic wr, input logic [4:0] a, input logic [15:0] d, input int stall);
      logic [15:0] exp;
      int          guard;
      guard = 0;
      while (!bus.req_ready && guard < 50) begin
         tick();
         guard++;
      end
      check("ready_wait", {31'd0, bus.req_ready}, 1);
      exp = wr ? d : ref_mem[a];
      if (wr) ref_mem[a] = d;
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = a;
      bus.req_wdata = d;
      bus.rsp_ready = 1'b0;
      tick();                              // accept edge
      bus.req_valid = 1'b0;
      bus.req_write = ~wr;
      bus.req_addr  = a + 5'd1;
      bus.req_wdata = ~d;
      check("acc_bus", {ram_write, ram_addr, bus.rsp_valid, bus.req_ready}, {wr, a, 1'b0, 1'b0});
      if (wr) check("acc_wdata", ram_in, d);
      tick();                              // ACCESS-ending edge
      check("rsp_lat", {bus.rsp_valid, ram_write, bus.req_ready}, 3'b100);
      check("rsp_data", bus.rsp_rdata, exp);
      for (int i = 0; i < stall; i++) begin
         tick();
         check("hold", {bus.rsp_valid, ram_write, bus.req_ready, bus.rsp_rdata}, {3'b100, exp});
      end
      bus.rsp_ready = 1'b1;
      tick();                              // response handshake edge
      bus.rsp_ready = 1'b0;
      check("rsp_done", {bus.rsp_valid, bus.req_ready, ram_write}, 3'b010);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      logic [4:0]  ra;
      logic [15:0] rd;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b0;
      rst_n = 1'b0;
      repeat (2) tick();
      scramble = 1'b0;
      tick();
      check("reset_vals", {ram_in, ram_addr, ram_write, bus.rsp_valid, bus.rsp_rdata,
                           init_done, bus.req_ready}, 0);

      // Zero-fill after reset release.
      run_clear();

      // Write then read address 0.
      do_op(1'b1, 5'd0, 16'h0070, 0);
      do_op(1'b0, 5'd0, 16'h0000, 0);

      // Cleared words read back as zero.
      do_op(1'b0, 5'd8, 16'h0000, 0);
      do_op(1'b0, 5'd31, 16'h0000, 0);

      // Response backpressure.
      do_op(1'b0, 5'd0, 16'h0000, 4);

      // Reset while a response is pending.
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 5'd0;
      tick();
      bus.req_valid = 1'b0;
      tick();
      check("resp_pending", {31'd0, bus.rsp_valid}, 1);
      rst_n = 1'b0;
      #1;
      check("rst_in_resp", {bus.rsp_valid, bus.rsp_rdata, init_done, ram_write}, 0);
      tick();
      run_clear();

      // Reset during the ACCESS cycle of a write: the write is lost.
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 5'd1; bus.req_wdata = 16'h0065;
      tick();
      bus.req_valid = 1'b0;
      check("pre_rst_wr", {ram_write, ram_addr}, {1'b1, 5'd1});
      rst_n = 1'b0;
      #1;
      check("rst_in_access", {ram_in, ram_addr, ram_write, bus.rsp_valid, bus.rsp_rdata,
                              init_done, bus.req_ready}, 0);
      tick();
      check("rst_held", {ram_write, init_done, bus.rsp_valid}, 3'b000);
      check("lost_wr", ram_mem[1], 16'h0000);
      run_clear();
      do_op(1'b0, 5'd1, 16'h0000, 0);

      // Pattern fill of all four 8-word blocks, then full read-back.
      for (int b = 0; b < 4; b++)
         for (int j = 0; j < 8; j++)
            do_op(1'b1, 5'(b * 8 + j), pat[j], int'($urandom_range(0, 2)));
      for (int a = 0; a < DEPTH; a++)
         do_op(1'b0, 5'(a), 16'h0000, int'($urandom_range(0, 2)));

      // Random traffic against the reference memory.
      for (int n = 0; n < 60; n++) begin
         ra = 5'($urandom);
         rd = 16'($urandom);
         do_op(1'($urandom), ra, rd, int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
